// File: rtl/sample_dma_receiver.sv
// Receives AXI read-data beats for per-voice DMA requests, writes them to the sample
// buffer at {voice id, beat index} and signals when the final request of a round has landed.
module sample_dma_receiver #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 6,
    parameter int BEATS_PER_REQ  = 64,
    parameter int BEAT_IDX_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                stop,
    input  logic [DATA_WIDTH-1:0]               dma_data,
    input  logic [ID_WIDTH-1:0]                 dma_data_id,
    input  logic                                dma_data_valid,
    input  logic                                dma_data_last,
    output logic                                dma_data_ready,
    input  logic                                last_request_sent,
    input  logic [ID_WIDTH-1:0]                 last_request_id,
    output logic                                all_samples_received,
    output logic [ID_WIDTH+BEAT_IDX_WIDTH-1:0]  buf_wr_addr,
    output logic [DATA_WIDTH-1:0]               buf_wr_data,
    output logic                                buf_wr_en,
    input  logic                                buf_wr_ready,
    output logic                                burst_len_error
);

    localparam int CNT_W = BEAT_IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0] BEATS    = CNT_W'(BEATS_PER_REQ);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS_PER_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     beat_idx;
    logic                 last_pending;
    logic [ID_WIDTH-1:0]  last_id_q;
    logic                 accept;
    logic                 in_range;
    logic [ID_WIDTH-1:0]  eff_last_id;
    logic                 final_match;
    logic                 capture_last;
    logic                 len_violation;

    assign dma_data_ready       = (state == RECEIVE) && buf_wr_ready;
    assign accept               = dma_data_valid && dma_data_ready;
    assign in_range             = (beat_idx < BEATS);
    assign all_samples_received = (state == DONE);
    assign capture_last         = last_request_sent && (state != IDLE);

    // A same-cycle announcement and final beat must still count as a match.
    assign eff_last_id = last_request_sent ? last_request_id : last_id_q;
    assign final_match = accept && dma_data_last
                         && (last_pending || last_request_sent)
                         && (dma_data_id == eff_last_id);

    assign len_violation = accept
                           && ((dma_data_last && (beat_idx != LAST_IDX)) || (beat_idx == BEATS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    next_state = RECEIVE;
                end
            end
            RECEIVE: begin
                if (final_match) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = start ? RECEIVE : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (stop) begin
            next_state = IDLE;
        end
    end

    // Write path and beat counter; stop discards whatever beat was accepted this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            beat_idx    <= '0;
        end else begin
            buf_wr_en <= 1'b0;
            if (stop) begin
                beat_idx <= '0;
            end else if (accept) begin
                if (in_range) begin
                    buf_wr_en   <= 1'b1;
                    buf_wr_addr <= {dma_data_id, beat_idx[BEAT_IDX_WIDTH-1:0]};
                    buf_wr_data <= dma_data;
                end
                if (dma_data_last) begin
                    beat_idx <= '0;
                end else if (in_range) begin
                    beat_idx <= beat_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pending <= 1'b0;
            last_id_q    <= '0;
        end else begin
            if (capture_last) begin
                last_id_q <= last_request_id;
            end
            if (stop || final_match) begin
                last_pending <= 1'b0;
            end else if (capture_last) begin
                last_pending <= 1'b1;
            end
        end
    end

    // Sticky until a fresh start out of IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_len_error <= 1'b0;
        end else if ((state == IDLE) && (next_state == RECEIVE)) begin
            burst_len_error <= 1'b0;
        end else if (!stop && len_violation) begin
            burst_len_error <= 1'b1;
        end
    end

endmodule

// File: doc/sample_dma_receiver.md
Name: sample_dma_receiver

Overview:
Data-side counterpart of the sample DMA requester. It accepts read-data beats returned by the AXI bridge for each per-voice DMA request and writes them into the sample buffer at {voice id, beat index}. It tracks the final request of a round, which the requester announces with last_request_sent/last_request_id. It pulses all_samples_received once the last beat of that final request has been written, which releases the requester for the next round.

Parameters:
DATA_WIDTH, 32, width of one sample beat
ID_WIDTH, 6, DMA request / voice id width
BEATS_PER_REQ, 64, beats per DMA request; must be a power of 2
BEAT_IDX_WIDTH, 6, log2(BEATS_PER_REQ)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  enable reception (level)
stop  in  1  abort and return to idle (level, priority over start)
dma_data  in  DATA_WIDTH  beat data from AXI bridge
dma_data_id  in  ID_WIDTH  id of the request this beat belongs to
dma_data_valid  in  1  beat valid
dma_data_last  in  1  last beat of the burst
dma_data_ready  out  1  beat accept
last_request_sent  in  1  single-cycle pulse: final request of the round issued
last_request_id  in  ID_WIDTH  id of that final request
all_samples_received  out  1  single-cycle pulse: final request's data fully written
buf_wr_addr  out  ID_WIDTH+BEAT_IDX_WIDTH  {id, beat index}
buf_wr_data  out  DATA_WIDTH  write data
buf_wr_en  out  1  write strobe
buf_wr_ready  in  1  buffer can accept a write
burst_len_error  out  1  sticky: a burst length differed from BEATS_PER_REQ

Behaviour:
- Reset values: dma_data_ready=0, all_samples_received=0, buf_wr_en=0, buf_wr_addr=0, buf_wr_data=0, burst_len_error=0, FSM=IDLE, beat_idx=0, last_pending=0, last_id_q=0.
- Accept condition: a beat is accepted when dma_data_valid && dma_data_ready. dma_data_ready = (FSM==RECEIVE) && buf_wr_ready, combinational.
- Bursts are never interleaved: all beats of one id arrive contiguously, terminated by dma_data_last.
- Write path, 1-cycle latency:
  - On each accepted beat with beat_idx < BEATS_PER_REQ: next cycle buf_wr_en=1, buf_wr_addr={dma_data_id, beat_idx}, buf_wr_data=dma_data. Otherwise buf_wr_en=0.
  - beat_idx increments per accepted beat and saturates at BEATS_PER_REQ (counter is BEAT_IDX_WIDTH+1 bits). It clears to 0 on an accepted beat with dma_data_last.
- Length check: set burst_len_error when an accepted beat with dma_data_last has beat_idx != BEATS_PER_REQ-1, or when a beat is accepted while beat_idx == BEATS_PER_REQ. Overflow beats are dropped and not written. burst_len_error clears only on the IDLE->RECEIVE transition.
- Last-request tracking: when last_request_sent=1, set last_pending=1 and last_id_q=last_request_id. It is captured in any state except IDLE.
- Final-beat match: an accepted beat with dma_data_last, (last_pending || last_request_sent), and id equal to the effective last id. The effective last id is last_request_id if last_request_sent is high that cycle, else last_id_q. A same-cycle pulse and final beat therefore count as a match.
- FSM states and transitions:
  - IDLE: wait for start && ~stop, then go to RECEIVE.
  - RECEIVE: accept beats; on a final-beat match go to DONE and clear last_pending.
  - DONE: lasts one cycle. all_samples_received=1, coincident with buf_wr_en for that final beat. Then go to RECEIVE if start, else IDLE.
  - stop=1 in any state: next state IDLE; clear last_pending and beat_idx; drop an in-flight write.
- A final beat whose id does not match last_id_q is a normal burst end and causes no pulse.
- Dropping start mid-round has no effect until DONE.
- Reset mid-burst: all state returns to reset values immediately.

Test Plan:
- Single round, ids 0..2, 64 beats each, with last_request_sent/id=2 pulsed after id 2 issues → 192 writes. Addresses 0x000–0x03F, 0x040–0x07F, 0x080–0x0BF. all_samples_received high exactly 1 cycle, the cycle after the 64th id-2 beat.
- buf_wr_ready toggling 1/0 every cycle during a 64-beat burst for id 5 → ready follows it, 64 writes at 0x140–0x17F, no lost or duplicate beats.
- last_request_sent with id 7 in the same cycle as id 7's final beat → all_samples_received pulses the next cycle.
- Burst of 63 beats with last on beat 63 → burst_len_error=1. A following 66-beat burst writes only 64 beats. Error stays 1 until the next IDLE→RECEIVE.
- stop asserted at beat 30 of the final request → FSM IDLE, no all_samples_received. After a restart, a fresh 64-beat burst writes from beat index 0.
- reset_n low mid-burst (beat 10) → all outputs 0 asynchronously, dma_data_ready=0 until start.
